// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing monitor. Samples active-low hsync/vsync on each
//   px_en_i strobe, locks onto the line/frame structure, reconstructs the
//   pixel position and flags any line or frame that breaks the expected
//   timing.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   px_en_i              pixel-rate strobe; nothing moves without it
//   hsync_i, vsync_i     active-low syncs
//   pixel_x_o/pixel_y_o  position of the last sample (0 unless locked)
//   visible_o            last sample is in the visible area while locked
//   locked_o             full horizontal + vertical lock
//   line_err_o           one-clock pulse on a horizontal violation
//   frame_err_o          one-clock pulse on a vertical violation
//   lock_loss_cnt_o      saturating count of LOCKED -> SEARCH drops
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525,
    parameter int SCREEN_H_RES = 640,
    parameter int SCREEN_V_RES = 480,
    parameter int HSYNC_START  = 656,
    parameter int HSYNC_END    = 752,
    parameter int VSYNC_START  = 490,
    parameter int VSYNC_END    = 492,
    parameter int X_POS_W      = 10,
    parameter int Y_POS_W      = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               px_en_i,
    input  logic               hsync_i,
    input  logic               vsync_i,
    output logic [X_POS_W-1:0] pixel_x_o,
    output logic [Y_POS_W-1:0] pixel_y_o,
    output logic               visible_o,
    output logic               locked_o,
    output logic               line_err_o,
    output logic               frame_err_o,
    output logic [7:0]         lock_loss_cnt_o
);

    typedef enum logic [1:0] {SEARCH, H_TRACK, V_TRACK, LOCKED} state_e;

    localparam logic [X_POS_W-1:0] H_LAST = X_POS_W'(H_TOTAL - 1);
    localparam logic [X_POS_W-1:0] H_VIS  = X_POS_W'(SCREEN_H_RES);
    localparam logic [X_POS_W-1:0] HS_S   = X_POS_W'(HSYNC_START);
    localparam logic [X_POS_W-1:0] HS_S1  = X_POS_W'(HSYNC_START + 1);
    localparam logic [X_POS_W-1:0] HS_E   = X_POS_W'(HSYNC_END);
    localparam logic [Y_POS_W-1:0] V_LAST = Y_POS_W'(V_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] V_VIS  = Y_POS_W'(SCREEN_V_RES);
    localparam logic [Y_POS_W-1:0] VS_S   = Y_POS_W'(VSYNC_START);
    localparam logic [Y_POS_W-1:0] VS_S1  = Y_POS_W'(VSYNC_START + 1);
    localparam logic [Y_POS_W-1:0] VS_E   = Y_POS_W'(VSYNC_END);

    state_e               state_q, state_d;
    logic [X_POS_W-1:0]   h_cnt_q, h_cnt_d;
    logic [Y_POS_W-1:0]   v_cnt_q, v_cnt_d;
    logic                 hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [X_POS_W-1:0]   pixel_x_q, pixel_x_d;
    logic [Y_POS_W-1:0]   pixel_y_q, pixel_y_d;
    logic                 visible_q, visible_d;
    logic                 line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic [7:0]           llc_q, llc_d;

    logic                 h_fall, h_rise, v_fall, v_rise, at_x0;
    logic                 l_err, f_err;
    logic [X_POS_W-1:0]   h_pos;
    logic [Y_POS_W-1:0]   v_pos;

    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        pixel_x_d   = pixel_x_q;
        pixel_y_d   = pixel_y_q;
        visible_d   = visible_q;
        llc_d       = llc_q;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;

        h_fall = hs_prev_q & ~hsync_i;
        h_rise = ~hs_prev_q & hsync_i;
        v_fall = vs_prev_q & ~vsync_i;
        v_rise = ~vs_prev_q & vsync_i;
        at_x0  = (h_cnt_q == '0);
        l_err  = 1'b0;
        f_err  = 1'b0;

        // Position of the current sample: the prediction, except where an
        // acquiring edge pins it to the sync start.
        h_pos = h_cnt_q;
        v_pos = v_cnt_q;
        if (state_q == SEARCH && h_fall) h_pos = HS_S;
        if (state_q == H_TRACK && v_fall && at_x0) v_pos = VS_S;

        if (state_q != SEARCH) begin
            // A sync edge that fails to appear where predicted is as much a
            // violation as one that appears in the wrong place.
            l_err = (h_fall && h_cnt_q != HS_S) || (h_rise && h_cnt_q != HS_E) ||
                    (h_cnt_q == HS_S1 && hsync_i) || (h_cnt_q == HS_E && !hsync_i);
        end
        if (state_q == V_TRACK || state_q == LOCKED) begin
            f_err = (v_fall && !(at_x0 && v_cnt_q == VS_S)) ||
                    (v_rise && !(at_x0 && v_cnt_q == VS_E)) ||
                    (at_x0 && v_cnt_q == VS_S1 && vsync_i) ||
                    (at_x0 && v_cnt_q == VS_E && !vsync_i);
        end

        if (px_en_i) begin
            hs_prev_d   = hsync_i;
            vs_prev_d   = vsync_i;
            line_err_d  = l_err;
            frame_err_d = f_err;

            unique case (state_q)
                SEARCH:  if (h_fall) state_d = H_TRACK;
                H_TRACK: if (l_err) state_d = SEARCH;
                         else if (v_fall && at_x0) state_d = V_TRACK;
                // No error on a vsync fall means it landed on VSYNC_START.
                V_TRACK: if (l_err || f_err) state_d = SEARCH;
                         else if (v_fall) state_d = LOCKED;
                LOCKED:  if (l_err || f_err) begin
                             state_d = SEARCH;
                             if (llc_q != 8'hff) llc_d = llc_q + 8'd1;
                         end
                default: state_d = SEARCH;
            endcase

            if (state_d == SEARCH) begin
                h_cnt_d = '0;
                v_cnt_d = '0;
            end else if (h_pos == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_pos == V_LAST) ? '0 : v_pos + Y_POS_W'(1);
            end else begin
                h_cnt_d = h_pos + X_POS_W'(1);
                v_cnt_d = v_pos;
            end

            if (state_d == LOCKED) begin
                pixel_x_d = h_pos;
                pixel_y_d = v_pos;
                visible_d = (h_pos < H_VIS) && (v_pos < V_VIS);
            end else begin
                pixel_x_d = '0;
                pixel_y_d = '0;
                visible_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= SEARCH;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            pixel_x_q   <= '0;
            pixel_y_q   <= '0;
            visible_q   <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            llc_q       <= '0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            pixel_x_q   <= pixel_x_d;
            pixel_y_q   <= pixel_y_d;
            visible_q   <= visible_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            llc_q       <= llc_d;
        end
    end

    assign pixel_x_o       = pixel_x_q;
    assign pixel_y_o       = pixel_y_q;
    assign visible_o       = visible_q;
    assign locked_o        = (state_q == LOCKED);
    assign line_err_o      = line_err_q;
    assign frame_err_o     = frame_err_q;
    assign lock_loss_cnt_o = llc_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;
  localparam int H_T = 12, SH = 8, HS = 9, HE = 11;
  localparam int V_T = 8,  SV = 4, VS = 5, VE = 7;
  localparam int FRAME = H_T * V_T;
  localparam int LOCK_MAX = 2 * FRAME + H_T;

  typedef struct {
    bit lock, lerr, ferr, chk, vis;
    int x, y, llc;
  } exp_t;

  logic gclk = 1'b0, grst_n = 1'b0;
  logic px_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [9:0] pixel_x, pixel_y;
  logic visible, locked, line_err, frame_err;
  logic [7:0] llc;

  vga_sync_decoder #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .SCREEN_H_RES(SH), .SCREEN_V_RES(SV),
    .HSYNC_START(HS), .HSYNC_END(HE), .VSYNC_START(VS), .VSYNC_END(VE),
    .X_POS_W(10), .Y_POS_W(10)
  ) dut (
    .clk_i(gclk), .rst_ni(grst_n), .px_en_i(px_en), .hsync_i(hsync), .vsync_i(vsync),
    .pixel_x_o(pixel_x), .pixel_y_o(pixel_y), .visible_o(visible), .locked_o(locked),
    .line_err_o(line_err), .frame_err_o(frame_err), .lock_loss_cnt_o(llc)
  );

  always #5 gclk = ~gclk;

  int n_chk = 0, n_fail = 0, vis_cnt = 0;
  exp_t sb[$];
  exp_t m_e;

  // generator position, injection knobs and spec-level lock tracking
  int gx = 3, gy = 1, px_div = 4, acq = 0, exp_llc = 0, hold_line = -1;
  bit prev_hs = 1, prev_vs = 1, skip_req = 0, pend_short = 0, vs3 = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge gclk) begin
    if (px_en) begin
      #2;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        m_e = sb.pop_front();
        chk("locked", locked, m_e.lock);
        chk("line_err", line_err, m_e.lerr);
        chk("frame_err", frame_err, m_e.ferr);
        chk("llc", llc, m_e.llc);
        if (m_e.chk) begin
          chk("px_x", pixel_x, m_e.x);
          chk("px_y", pixel_y, m_e.y);
          chk("visible", visible, m_e.vis);
        end
        if (visible) vis_cnt++;
      end
    end else if (grst_n) begin
      #2;
      chk("pulse_w", {line_err, frame_err}, 0);
    end
  end

  task automatic step();
    logic hs, vs, hf, vf;
    exp_t e;
    hs = !(gx >= HS && gx < HE) || (gy == hold_line);
    vs = vs3 ? !(gy >= VS && gy <= VE) : !(gy >= VS && gy < VE);
    hf = prev_hs && !hs;
    vf = prev_vs && !vs;
    e.lerr = (acq != 0) && ((pend_short && hf) || (gy == hold_line && gx == HS + 1));
    e.ferr = (acq >= 2) && vs3 && gx == 0 && gy == VE;
    if (hf) pend_short = 0;
    if (e.lerr || e.ferr) begin
      if (acq == 3 && exp_llc < 255) exp_llc++;
      acq = 0;
    end else if (acq == 0 && hf) acq = 1;
    else if (acq == 1 && vf) acq = 2;
    else if (acq == 2 && vf) acq = 3;
    e.lock = (acq == 3);
    e.chk  = !pend_short;
    e.x    = e.lock ? gx : 0;
    e.y    = e.lock ? gy : 0;
    e.vis  = e.lock && gx < SH && gy < SV;
    e.llc  = exp_llc;
    sb.push_back(e);
    hsync = hs; vsync = vs; px_en = 1'b1;
    @(negedge gclk);
    px_en = 1'b0;
    repeat (px_div - 1) @(negedge gclk);
    prev_hs = hs; prev_vs = vs;
    if (skip_req && gx == H_T - 2) begin
      gx = 0; gy = (gy + 1) % V_T; skip_req = 0; pend_short = 1;
    end else begin
      gx++;
      if (gx == H_T) begin gx = 0; gy = (gy + 1) % V_T; end
    end
    if (gx == 0 && gy == 0) vs3 = 0;
    if (gx == 0 && hold_line >= 0 && gy == (hold_line + 1) % V_T) hold_line = -1;
  endtask

  task automatic run_to(input int tx, input int ty);
    int n = 0;
    while (!(gx == tx && gy == ty) && n < 2 * FRAME) begin step(); n++; end
    if (n >= 2 * FRAME) chk("run_to_timeout", 0, 1);
  endtask

  task automatic relock(input string tag);
    int n = 0;
    while (acq != 3 && n < 3 * FRAME) begin step(); n++; end
    chk(tag, locked, 1);
    chk({tag, "_lat"}, n <= LOCK_MAX, 1);
  endtask

  task automatic wait_loss(input string tag);
    int n = 0;
    while (acq != 0 && n < 2 * FRAME) begin step(); n++; end
    chk(tag, locked, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, pixel_x, 0);
    chk({tag, "_y"}, pixel_y, 0);
    chk({tag, "_vis"}, visible, 0);
    chk({tag, "_lock"}, locked, 0);
    chk({tag, "_lerr"}, line_err, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_llc"}, llc, 0);
  endtask

  initial begin
    int v0;
    @(negedge gclk);
    chk_all_zero("rst");
    grst_n = 1'b1;

    // clean acquisition and one full locked frame
    relock("lock_pwrup");
    run_to(0, 0);
    v0 = vis_cnt;
    repeat (FRAME) step();
    chk("vis_per_frame", vis_cnt - v0, SH * SV);

    // one line short by a pixel
    run_to(0, 1);
    skip_req = 1;
    wait_loss("short_line_loss");
    chk("short_line_llc", llc, 1);
    relock("short_line_relock");

    // hsync held high for a whole line
    run_to(0, 2);
    hold_line = 2;
    wait_loss("no_hsync_loss");
    relock("no_hsync_relock");

    // vsync low for three lines
    run_to(0, 1);
    vs3 = 1;
    wait_loss("vs3_loss");
    chk("vs3_llc", llc, 3);
    relock("vs3_relock");

    // enough forced drops to saturate the loss counter
    px_div = 1;
    for (int i = 0; i < 300; i++) begin
      run_to(0, 1);
      skip_req = 1;
      wait_loss("sat_loss");
      relock("sat_relock");
    end
    chk("llc_sat", llc, 255);

    // async reset mid-frame while locked
    px_div = 4;
    run_to(2, 3);
    grst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    acq = 0; exp_llc = 0; prev_hs = 1; prev_vs = 1;
    relock("lock_after_rst");
    repeat (H_T) step();

    repeat (4) @(negedge gclk);
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
